// File: rtl/sqrt_arb_pkg.sv
// Shared types and default sizing for the sqrt arbiter.
// Optional watchdog: SQRT_ARB_TIMEOUT_EN.
package sqrt_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GO,
      S_CLEAR,
      S_WAIT,
      S_RESP
   } arb_state_e;

   localparam int N_DEF       = 4;
   localparam int W_DEF       = 8;
   localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/sqrt_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          vld,
   output logic [PW-1:0] gidx
);

   int            idx;
   logic [PW-1:0] sel;

   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      vld  = 1'b0;
      gidx = '0;
      idx  = 0;
      sel  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = PW'(idx);
         if (req[sel]) begin
            vld  = 1'b1;
            gidx = sel;
         end
      end
   end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one go/done square-root unit among N requesters.
// Define SQRT_ARB_TIMEOUT_EN to add the CLEAR/WAIT watchdog and err output.
module sqrt_arbiter
   import sqrt_arb_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int W       = W_DEF,
   parameter int RW      = W / 2,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic           clk,
   input  logic           clr,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] opnd,
   output logic [N-1:0]   ack,
   output logic [RW-1:0]  res,
   output logic           err,
   output logic           busy,
   output logic           go,
   output logic [W-1:0]   sw,
   input  logic           done,
   input  logic [RW-1:0]  root
);

   localparam int PW = $clog2(N);

   if (N < 2 || N > 8 || W < 2 || TIMEOUT < 2) begin : g_bad_cfg
      $error("sqrt_arbiter: unsupported parameter set");
   end

   arb_state_e    state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] gidx_q, gidx_d;
   logic [W-1:0]  sw_q, sw_d;
   logic [RW-1:0] res_q, res_d;

   logic          pick_vld;
   logic [PW-1:0] pick_idx;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req  (req),
      .ptr  (ptr_q),
      .vld  (pick_vld),
      .gidx (pick_idx)
   );

`ifdef SQRT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          tmo;

   // Fires on the cycle the count would reach TIMEOUT-1.
   assign tmo = (state_q == S_CLEAR || state_q == S_WAIT) &&
                (cnt_q + 1'b1 == CW'(TIMEOUT - 1));
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      sw_d    = sw_q;
      res_d   = res_q;
`ifdef SQRT_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               gidx_d  = pick_idx;
               sw_d    = opnd[pick_idx*W +: W];
               state_d = S_GO;
`ifdef SQRT_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         S_GO: state_d = S_CLEAR;
         S_CLEAR: begin
`ifdef SQRT_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (!done) state_d = S_WAIT;
         end
         S_WAIT: begin
`ifdef SQRT_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (done) begin
               res_d   = root;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            ptr_d   = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;
            state_d = S_IDLE;
`ifdef SQRT_ARB_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         default: state_d = S_IDLE;
      endcase
`ifdef SQRT_ARB_TIMEOUT_EN
      // A real completion in WAIT beats a coincident timeout.
      if (tmo && !(state_q == S_WAIT && done)) begin
         res_d   = '0;
         err_d   = 1'b1;
         state_d = S_RESP;
      end
`endif
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         sw_q    <= '0;
         res_q   <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         sw_q    <= sw_d;
         res_q   <= res_d;
`ifdef SQRT_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      ack = '0;
      if (state_q == S_RESP) ack[gidx_q] = 1'b1;
   end

   assign res  = res_q;
   assign sw   = sw_q;
   assign go   = (state_q == S_GO);
   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural go/done sqrt unit.
// Timeout scenario is compiled only with SQRT_ARB_TIMEOUT_EN.
module tb_sqrt_arbiter;

   logic        clk = 1'b0;
   logic        clr;
   logic [3:0]  req;
   logic [31:0] opnd;
   logic [3:0]  ack;
   logic [3:0]  res;
   logic        err;
   logic        busy;
   logic        go;
   logic [7:0]  sw;
   logic        done;
   logic [3:0]  root;

   int total = 0;
   int bad   = 0;
   int go_cnt = 0;

   int lat        = 10;
   int stale      = 0;
   bit never_done = 1'b0;

   always #5 clk = ~clk;

   sqrt_arbiter #(
      .N       (4),
      .W       (8),
      .RW      (4),
      .TIMEOUT (64)
   ) dut (
      .clk  (clk),
      .clr  (clr),
      .req  (req),
      .opnd (opnd),
      .ack  (ack),
      .res  (res),
      .err  (err),
      .busy (busy),
      .go   (go),
      .sw   (sw),
      .done (done),
      .root (root)
   );

   function automatic logic [3:0] isqrt(input logic [7:0] v);
      for (int r = 15; r >= 0; r--)
         if (r * r <= int'(v)) return 4'(r);
      return 4'd0;
   endfunction

   // Sqrt unit model: done is a level held until the next go.
   logic [7:0] op_l;
   int         scnt;
   int         ccnt;
   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         done <= 1'b0;
         root <= '0;
         op_l <= '0;
         scnt <= 0;
         ccnt <= 0;
      end else if (go) begin
         op_l <= sw;
         scnt <= stale;
         ccnt <= lat;
         if (stale == 0) done <= 1'b0;
      end else if (scnt > 0) begin
         scnt <= scnt - 1;
         if (scnt == 1) done <= 1'b0;
      end else if (ccnt > 0) begin
         ccnt <= ccnt - 1;
         if (ccnt == 1 && !never_done) begin
            done <= 1'b1;
            root <= isqrt(op_l);
         end
      end
   end

   always @(posedge clk) if (clr && go) go_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic apply_reset();
      clr = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_ack(input int budget, output bit found,
                           output int cyc);
      found = 1'b0;
      cyc   = 0;
      while (!found && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (ack != 4'b0) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      clr  = 1'b0;
      req  = '0;
      opnd = '0;
      repeat (2) @(negedge clk);
      total++;
      if (ack !== 4'b0) begin
         bad++; $display("FAIL reset_ack: got %b want 0000", ack);
      end
      total++;
      if (res !== 4'd0) begin
         bad++; $display("FAIL reset_res: got %0d want 0", res);
      end
      total++;
      if (err !== 1'b0) begin
         bad++; $display("FAIL reset_err: got %b want 0", err);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      total++;
      if (go !== 1'b0) begin
         bad++; $display("FAIL reset_go: got %b want 0", go);
      end
      total++;
      if (sw !== 8'd0) begin
         bad++; $display("FAIL reset_sw: got %0d want 0", sw);
      end
      clr = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      bit f;
      int c;
      int g0;
      lat  = 10;
      stale = 0;
      g0   = go_cnt;
      opnd[7:0] = 8'd144;
      req  = 4'b0001;
      wait_ack(200, f, c);
      total++;
      if (!f) begin
         bad++; $display("FAIL single_ack_seen: got none want ack");
      end
      total++;
      if (c !== 13) begin
         bad++; $display("FAIL single_latency: got %0d want 13", c);
      end
      total++;
      if (ack !== 4'b0001) begin
         bad++; $display("FAIL single_ack: got %b want 0001", ack);
      end
      total++;
      if (res !== 4'd12) begin
         bad++; $display("FAIL single_res: got %0d want 12", res);
      end
      total++;
      if (err !== 1'b0) begin
         bad++; $display("FAIL single_err: got %b want 0", err);
      end
      total++;
      if (sw !== 8'd144) begin
         bad++; $display("FAIL single_sw: got %0d want 144", sw);
      end
      total++;
      if (go_cnt - g0 !== 1) begin
         bad++; $display("FAIL single_go_pulses: got %0d want 1", go_cnt - g0);
      end
      req = '0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL single_busy_after: got %b want 0", busy);
      end
      total++;
      if (ack !== 4'b0) begin
         bad++; $display("FAIL single_ack_width: got %b want 0000", ack);
      end
   endtask

   task automatic test_all_four();
      int er[4] = '{0, 1, 15, 10};
      bit f;
      int c;
      apply_reset();
      opnd = {8'd100, 8'd255, 8'd1, 8'd0};
      req  = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_ack(200, f, c);
         total++;
         if (!f) begin
            bad++; $display("FAIL all4_seen[%0d]: got none want ack", i);
         end
         total++;
         if (ack !== 4'(1 << i)) begin
            bad++; $display("FAIL all4_ack[%0d]: got %b want %b",
                            i, ack, 4'(1 << i));
         end
         total++;
         if (res !== 4'(er[i])) begin
            bad++; $display("FAIL all4_res[%0d]: got %0d want %0d",
                            i, res, er[i]);
         end
         req[i] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_stale_done();
      bit f;
      int c;
      stale = 3;
      opnd[31:24] = 8'd81;
      req = 4'b1000;
      wait_ack(200, f, c);
      total++;
      if (c !== 16) begin
         bad++; $display("FAIL stale_latency: got %0d want 16", c);
      end
      total++;
      if (ack !== 4'b1000) begin
         bad++; $display("FAIL stale_ack: got %b want 1000", ack);
      end
      total++;
      if (res !== 4'd9) begin
         bad++; $display("FAIL stale_res: got %0d want 9", res);
      end
      req   = '0;
      stale = 0;
      @(negedge clk);
   endtask

   task automatic test_fairness();
      int ei[6] = '{0, 2, 0, 2, 0, 2};
      int er[6] = '{4, 15, 4, 15, 4, 15};
      bit f;
      int c;
      opnd[7:0]   = 8'd16;
      opnd[23:16] = 8'd225;
      req = 4'b0101;
      for (int i = 0; i < 6; i++) begin
         wait_ack(200, f, c);
         total++;
         if (ack !== 4'(1 << ei[i])) begin
            bad++; $display("FAIL fair_ack[%0d]: got %b want %b",
                            i, ack, 4'(1 << ei[i]));
         end
         total++;
         if (res !== 4'(er[i])) begin
            bad++; $display("FAIL fair_res[%0d]: got %0d want %0d",
                            i, res, er[i]);
         end
      end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_in_wait();
      bit f;
      int c;
      opnd[15:8] = 8'd49;
      req = 4'b0010;
      repeat (6) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL midrst_busy_before: got %b want 1", busy);
      end
      #2 clr = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL midrst_busy: got %b want 0", busy);
      end
      total++;
      if (sw !== 8'd0) begin
         bad++; $display("FAIL midrst_sw: got %0d want 0", sw);
      end
      total++;
      if (res !== 4'd0) begin
         bad++; $display("FAIL midrst_res: got %0d want 0", res);
      end
      total++;
      if (ack !== 4'b0 || go !== 1'b0) begin
         bad++; $display("FAIL midrst_ack_go: got %b/%b want 0000/0", ack, go);
      end
      @(negedge clk);
      clr = 1'b1;
      wait_ack(200, f, c);
      total++;
      if (c !== 13) begin
         bad++; $display("FAIL midrst_latency: got %0d want 13", c);
      end
      total++;
      if (ack !== 4'b0010) begin
         bad++; $display("FAIL midrst_ack: got %b want 0010", ack);
      end
      total++;
      if (res !== 4'd7) begin
         bad++; $display("FAIL midrst_res_after: got %0d want 7", res);
      end
      req = '0;
      @(negedge clk);
   endtask

`ifdef SQRT_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit f;
      int c;
      never_done = 1'b1;
      opnd[7:0]  = 8'd144;
      req = 4'b0001;
      wait_ack(200, f, c);
      total++;
      if (c !== 65) begin
         bad++; $display("FAIL tmo_latency: got %0d want 65", c);
      end
      total++;
      if (ack !== 4'b0001) begin
         bad++; $display("FAIL tmo_ack: got %b want 0001", ack);
      end
      total++;
      if (err !== 1'b1) begin
         bad++; $display("FAIL tmo_err: got %b want 1", err);
      end
      total++;
      if (res !== 4'd0) begin
         bad++; $display("FAIL tmo_res: got %0d want 0", res);
      end
      req = '0;
      never_done = 1'b0;
      @(negedge clk);
      opnd[15:8] = 8'd49;
      req = 4'b0010;
      wait_ack(200, f, c);
      total++;
      if (res !== 4'd7 || err !== 1'b0) begin
         bad++; $display("FAIL tmo_next: got res=%0d err=%b want 7/0", res, err);
      end
      req = '0;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_stale_done();
      test_fairness();
      test_reset_in_wait();
`ifdef SQRT_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares a single iterative square-root unit (go/done handshake, 8-bit operand, 4-bit root) among N requesters.
- Round-robin grants; drives the unit's go and operand; waits for done; captures root; returns it to the granted requester with a one-cycle ack.
- Sits between requester logic (button/switch front-ends, other FSMs) and the sqrt datapath, in the clk25 domain.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand width.
- RW, W/2, root width.
- TIMEOUT, 64, watchdog cycle limit. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- clr  in  1  asynchronous active-low reset.
- req  in  N  level request per requester; held until its ack.
- opnd  in  N*W  packed operands; requester i uses bits [i*W +: W]; stable while req[i] is high.
- ack  out  N  one-hot, one-cycle pulse to the served requester.
- res  out  RW  root for the served requester; valid in the ack cycle, held afterwards.
- err  out  1  pulses with ack when the operation timed out (tied 0 without the optional feature).
- busy  out  1  high in every state except IDLE.
- go  out  1  one-cycle start pulse to the sqrt unit.
- sw  out  W  operand to the sqrt unit; registered and held from GO until the next grant.
- done  in  1  sqrt unit completion, level.
- root  in  RW  sqrt unit result; valid while done is high.

Behaviour:
- Reset (clr=0, async):
  - State IDLE; ack=0, res=0, err=0, busy=0, go=0, sw=0.
  - Round-robin pointer ptr=0; granted index gidx=0.
- States: IDLE, GO, CLEAR, WAIT, RESP.
- IDLE:
  - If req is nonzero, pick the first set bit searching from ptr upward, with wrap-around.
  - Latch gidx, latch sw <= opnd[gidx], go to GO.
  - If req is zero, stay in IDLE.
- GO: go=1 for exactly this cycle; next state CLEAR.
- CLEAR:
  - Wait for done==0. This rejects a stale done left over from the previous operation.
  - On done==0, go to WAIT.
- WAIT: on done==1, res <= root, go to RESP.
- RESP:
  - ack[gidx]=1 for exactly this cycle; ptr <= gidx+1 (mod N); next state IDLE.
  - IDLE therefore evaluates requests no earlier than the cycle after ack.
- Latency: grant to ack is at least 4 cycles plus the sqrt unit's compute time. Request to grant is 1 cycle when in IDLE.
- Requester rule: drop req in the cycle after ack. If req[i] is still high when IDLE samples it, that is a new request, but the requester has lowest priority because ptr has moved past it.
- Simultaneous requests: strictly round-robin. With all N requests held continuously, each requester is served once per N operations.
- A req deasserted after grant has no effect; the operation completes and ack is still issued.
- Reset mid-operation returns the arbiter to IDLE immediately. The sqrt unit must share the reset.
- Only one operation is ever outstanding; go is never asserted outside GO.

Optional Feature:
- Macro SQRT_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter clears on entry to GO and increments in CLEAR and WAIT.
  - If the counter reaches TIMEOUT-1 without completion, go to RESP with res=0 and err=1, pulsed together with ack.
- When undefined: no counter, err is tied to 0, and the arbiter can wait forever in CLEAR or WAIT.

Decomposition:
- Package sqrt_arb_pkg:
  - State enum typedef (IDLE, GO, CLEAR, WAIT, RESP).
  - Default constants for N, W, TIMEOUT.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req and ptr; outputs are a valid flag and gidx (first set bit at or after ptr, wrapping).
- FSM, registers and the optional watchdog live in sqrt_arbiter.

Test Plan:
- Single request, bus model has 10-cycle compute: req=4'b0001, opnd0=144 -> go pulse once, sw=144, ack=4'b0001 with res=12, err=0, busy low the cycle after ack.
- All four requesting together, operands 0, 1, 255, 100, ptr=0 -> acks in order 0,1,2,3 with res 0, 1, 15, 10.
- Stale done: model holds done=1 from the prior op for 3 cycles after go -> arbiter stays in CLEAR and does not ack until the fresh done; res equals the new root.
- Fairness: req0 and req2 held continuously for 6 operations -> acks alternate 0,2,0,2,0,2.
- Reset asserted during WAIT -> outputs return to reset values asynchronously. After release, a new req1 (opnd=49) yields res=7.
- With SQRT_ARB_TIMEOUT_EN and TIMEOUT=64, model never raises done -> ack plus err=1 and res=0 on cycle 64 after GO entry; the next request is served normally.
